fb_reader: RTL and testbench
============================

FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, pixel return FIFO entries, power of two, 4 to 64.
REQ-002 SHALL have clk  in  1  clock; all logic rising-edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have start  in  1  begin one frame readout; sampled only in IDLE.
REQ-005 SHALL have busy  out  1  high in any state other than IDLE.
REQ-006 SHALL have frame_done  out  1  one-cycle pulse after the final pixel handshake.
REQ-007 SHALL have ddr3_app_rdy  in  1  DDR3 controller accepts command.
REQ-008 SHALL have ddr3_app_en  out  1  command valid.
REQ-009 SHALL have ddr3_app_cmd  out  3  constant 3'b001 (read).
REQ-010 SHALL have ddr3_app_addr  out  FB_ADDR_WIDTH  read word address.
REQ-011 SHALL have ddr3_app_rd_data_valid  in  1  read data beat valid.
REQ-012 SHALL have ddr3_app_rd_data  in  64  read data, one pixel per beat.
REQ-013 SHALL have pix_valid  out  1, pix_ready  in  1, pix_data  out  64: pixel stream.
REQ-014 SHALL have pix_last  out  1  marks the final pixel of the frame.
REQ-015 SHALL have overflow_err  out  1  sticky; set on a read beat arriving while the FIFO is full.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-017 IDLE: start=1 SHALL clear the issue, pop and address counters, set credits=FIFO_DEPTH and enter ISSUE; start while busy SHALL be ignored.
REQ-018 ISSUE: SHALL assert ddr3_app_en when credits>0; once asserted, app_en and app_addr SHALL hold until app_rdy=1.
REQ-019 A command is accepted when app_en=1 and app_rdy=1; addr SHALL then advance by 8; the first address is 0; total reads = SCREEN_WIDTH*SCREEN_HEIGHT.
REQ-020 After the last read is accepted, the FSM SHALL enter DRAIN; no further app_en SHALL be asserted for that frame.
REQ-021 credits SHALL decrement on an accepted command and increment on a pix handshake; both in one cycle SHALL leave credits unchanged; credits SHALL never exceed FIFO_DEPTH or go below 0.
REQ-022 Each rd_data_valid beat SHALL be written to the FIFO in arrival order (in-order return from DDR3).
REQ-023 pix_valid SHALL be FIFO-not-empty; pix_data SHALL be the head entry; the latency from rd_data_valid to pix_valid is exactly 1 cycle with the FIFO empty.
REQ-024 pix_data SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-025 Pixels SHALL emit in raster order (x fastest, then y); pix_last=1 only with the pixel whose pop count = total-1.
REQ-026 A FIFO write and pop in the same cycle SHALL both occur, occupancy unchanged; a pop with the FIFO full SHALL be legal.
REQ-027 DRAIN: on the final pix handshake, the block SHALL pulse frame_done for one cycle on the next cycle and enter IDLE.
REQ-028 rd_data_valid in IDLE SHALL be discarded without setting overflow_err.
REQ-029 overflow_err SHALL set on rd_data_valid with the FIFO full outside IDLE; the beat SHALL be dropped; the flag SHALL clear only on rst.

Reset
REQ-030 rst SHALL force IDLE; busy=0, frame_done=0, ddr3_app_en=0, ddr3_app_addr=0, pix_valid=0, pix_last=0, overflow_err=0, FIFO empty, credits=FIFO_DEPTH.
REQ-031 rst mid-frame SHALL abandon the frame at once with no frame_done; the next start SHALL restart at address 0.

Configuration
REQ-032 With macro FB_READER_EOL_EN defined, the block SHALL add port pix_eol  out  1, high with each pixel whose x = SCREEN_WIDTH-1, reset 0.
REQ-033 Without FB_READER_EOL_EN, pix_eol SHALL be absent and all other behaviour SHALL be identical.

Verification (SCREEN_WIDTH=4, SCREEN_HEIGHT=2, FIFO_DEPTH=4)
REQ-034 Test 1: start, app_rdy=1, data returns 2 cycles after each command with value=addr, pix_ready=1 -> addrs 0,8,...,56; pix_data 0..56 in order; pix_last on 8th; frame_done 1 cycle later.
REQ-035 Test 2: pix_ready=0 throughout -> exactly 4 commands accepted, then app_en=0; after pix_ready=1, remaining 4 issue and all 8 pixels are delivered.
REQ-036 Test 3: app_rdy=0 for 5 cycles at first command -> app_en=1 and addr=0 held stable for those 5 cycles.
REQ-037 Test 4: inject rd_data_valid with 4 entries queued and pix_ready=0 -> overflow_err=1 and stays 1 until rst.
REQ-038 Test 5: rst after 3 pixels -> all outputs at reset values next cycle, no frame_done; a new start reads from addr 0.
REQ-039 Test 6: FB_READER_EOL_EN defined -> pix_eol high on pixels 4 and 8 only.

Source files
------------

// File: rtl/fb_reader_if.sv
// rtl/fb_reader_if.sv - DDR3 read command/return and pixel stream bundle for fb_reader (pix_eol under FB_READER_EOL_EN)
interface fb_reader_if #(
  parameter int FB_ADDR_WIDTH = 28
);
  logic                     ddr3_app_rdy;
  logic                     ddr3_app_en;
  logic [2:0]               ddr3_app_cmd;
  logic [FB_ADDR_WIDTH-1:0] ddr3_app_addr;
  logic                     ddr3_app_rd_data_valid;
  logic [63:0]              ddr3_app_rd_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [63:0]              pix_data;
  logic                     pix_last;
`ifdef FB_READER_EOL_EN
  logic                     pix_eol;
`endif

  modport master (
    input  ddr3_app_rdy, ddr3_app_rd_data_valid, ddr3_app_rd_data, pix_ready,
    output ddr3_app_en, ddr3_app_cmd, ddr3_app_addr, pix_valid, pix_data, pix_last
`ifdef FB_READER_EOL_EN
    , output pix_eol
`endif
  );

  modport slave (
    output ddr3_app_rdy, ddr3_app_rd_data_valid, ddr3_app_rd_data, pix_ready,
    input  ddr3_app_en, ddr3_app_cmd, ddr3_app_addr, pix_valid, pix_data, pix_last
`ifdef FB_READER_EOL_EN
    , input pix_eol
`endif
  );
endinterface

// File: rtl/fb_reader.sv
// rtl/fb_reader.sv - credit-throttled DDR3 frame buffer reader with pixel return FIFO; FB_READER_EOL_EN adds pix_eol
module fb_reader #(
  parameter int FIFO_DEPTH    = 16,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FB_ADDR_WIDTH = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow_err,
  fb_reader_if.master bus
);
  localparam int TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int X_W   = $clog2(SCREEN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(SCREEN_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]         pop_cnt_q, pop_cnt_d;
  logic [FB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OCC_W-1:0]         credits_q, credits_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [X_W-1:0]           x_q, x_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overflow_q, overflow_d;
  logic [63:0]              mem_q [FIFO_DEPTH];

  logic app_en, cmd_acc, pix_pop, last_pop, fifo_full, fifo_wr;

  // Credits reserve FIFO space per outstanding read, so app_en stays up until accepted.
  assign app_en    = (state_q == S_ISSUE) && (credits_q != '0);
  assign cmd_acc   = app_en && bus.ddr3_app_rdy;
  assign pix_pop   = (occ_q != '0) && bus.pix_ready;
  assign last_pop  = pix_pop && (pop_cnt_q == LAST_IDX);
  assign fifo_full = (occ_q == DEPTH_C);
  assign fifo_wr   = bus.ddr3_app_rd_data_valid && (state_q != S_IDLE) && !fifo_full;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    addr_d       = addr_q;
    credits_d    = credits_q;
    occ_d        = occ_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    x_d          = x_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pix_pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      pop_cnt_d = pop_cnt_q + CNT_W'(1);
      x_d       = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
    end
    if (fifo_wr && !pix_pop)      occ_d = occ_q + OCC_W'(1);
    else if (!fifo_wr && pix_pop) occ_d = occ_q - OCC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          addr_d      = '0;
          credits_d   = DEPTH_C;
          occ_d       = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          x_d         = '0;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (cmd_acc) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          addr_d      = addr_q + FB_ADDR_WIDTH'(8);
          if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
        if (cmd_acc && !pix_pop) credits_d = credits_q - OCC_W'(1);
        else if (!cmd_acc && pix_pop && credits_q != DEPTH_C) credits_d = credits_q + OCC_W'(1);
        if (bus.ddr3_app_rd_data_valid && fifo_full) overflow_d = 1'b1;
        if (last_pop) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      pop_cnt_q    <= '0;
      addr_q       <= '0;
      credits_q    <= DEPTH_C;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      x_q          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      addr_q       <= addr_d;
      credits_q    <= credits_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      x_q          <= x_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= bus.ddr3_app_rd_data;
  end

  assign busy              = (state_q != S_IDLE);
  assign frame_done        = frame_done_q;
  assign overflow_err      = overflow_q;
  assign bus.ddr3_app_en   = app_en;
  assign bus.ddr3_app_cmd  = 3'b001;
  assign bus.ddr3_app_addr = addr_q;
  assign bus.pix_valid     = (occ_q != '0);
  assign bus.pix_data      = mem_q[rd_ptr_q];
  assign bus.pix_last      = (occ_q != '0) && (pop_cnt_q == LAST_IDX);
`ifdef FB_READER_EOL_EN
  assign bus.pix_eol       = (occ_q != '0) && (x_q == X_LAST);
`endif
endmodule

// File: tb/tb_fb_reader.sv
// tb/tb_fb_reader.sv - randomized self-checking bench for fb_reader against a queue-based frame model
module tb_fb_reader;
  localparam int W = 4, H = 2, D = 4, AW = 16, TOTAL = W * H;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, frame_done, overflow_err;

  fb_reader_if #(.FB_ADDR_WIDTH(AW)) bus ();

  fb_reader #(.FIFO_DEPTH(D), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .overflow_err(overflow_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: frame progress as counts, FIFO contents as a queue
  bit m_busy = 0, m_fd = 0, m_ovf = 0;
  int n_iss = 0, n_pop = 0;
  logic [63:0] fifo_q[$];
  int due_q[$];
  logic [63:0] dat_q[$];
  int last_due = 0;

  int rdy_pct = 100, pix_pct = 100, lat_min = 2, lat_max = 2;
  bit rst_req = 1, start_req = 0, inject = 0, spam = 0;
  logic [31:0] tag = '0;

  logic [63:0] seen_q[$];
  logic [AW-1:0] acc_addr_q[$];
  bit last_seen[$];
  bit eol_seen[$];
  int acc_seen = 0, fd_count = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit busy_pre, do_pop, acc, exp_en;
    int due, lat;
    logic [AW-1:0] a;
    @(negedge clk);
    cyc++;
    exp_en = m_busy && (n_iss < TOTAL) && ((n_iss - n_pop) < D);
    check("busy", 64'(busy), 64'(m_busy));
    check("frame_done", 64'(frame_done), 64'(m_fd));
    check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    check("app_cmd", 64'(bus.ddr3_app_cmd), 64'(3'b001));
    check("app_en", 64'(bus.ddr3_app_en), 64'(exp_en));
    if (exp_en) check("app_addr", 64'(bus.ddr3_app_addr), 64'(8 * n_iss));
    check("pix_valid", 64'(bus.pix_valid), 64'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) begin
      check("pix_data", bus.pix_data, fifo_q[0]);
      check("pix_last", 64'(bus.pix_last), 64'(n_pop == TOTAL - 1));
`ifdef FB_READER_EOL_EN
      check("pix_eol", 64'(bus.pix_eol), 64'((n_pop % W) == W - 1));
`endif
    end else begin
      check("pix_last_empty", 64'(bus.pix_last), 64'(0));
    end

    rst   = rst_req;
    start = start_req || (spam && $urandom_range(9) == 0);
    bus.ddr3_app_rdy = (int'($urandom_range(99)) < rdy_pct);
    bus.pix_ready    = (int'($urandom_range(99)) < pix_pct);
    if (inject) begin
      bus.ddr3_app_rd_data_valid = 1'b1;
      bus.ddr3_app_rd_data = {$urandom, $urandom};
    end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
      bus.ddr3_app_rd_data_valid = 1'b1;
      bus.ddr3_app_rd_data = dat_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      bus.ddr3_app_rd_data_valid = 1'b0;
      bus.ddr3_app_rd_data = {$urandom, $urandom};
    end

    if (bus.ddr3_app_en && bus.ddr3_app_rdy) begin
      acc_seen++;
      acc_addr_q.push_back(bus.ddr3_app_addr);
    end
    if (bus.pix_valid && bus.pix_ready) begin
      seen_q.push_back(bus.pix_data);
      last_seen.push_back(bus.pix_last);
`ifdef FB_READER_EOL_EN
      eol_seen.push_back(bus.pix_eol);
`endif
    end
    if (frame_done) fd_count++;

    if (rst) begin
      m_busy = 0; m_fd = 0; m_ovf = 0; n_iss = 0; n_pop = 0;
      fifo_q.delete(); due_q.delete(); dat_q.delete(); last_due = 0;
      return;
    end
    busy_pre = m_busy;
    acc      = exp_en && bus.ddr3_app_rdy;
    do_pop   = bus.pix_ready && (fifo_q.size() != 0);
    m_fd     = 0;
    if (bus.ddr3_app_rd_data_valid && busy_pre) begin
      if (fifo_q.size() == D) m_ovf = 1;
      else fifo_q.push_back(bus.ddr3_app_rd_data);
    end
    if (do_pop) begin
      void'(fifo_q.pop_front());
      if (busy_pre && n_pop == TOTAL - 1) begin
        m_busy = 0;
        m_fd = 1;
      end
      n_pop++;
    end
    if (acc) begin
      a = AW'(8 * n_iss);
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
      dat_q.push_back({tag, 16'h0, a});
      n_iss++;
    end
    if (start && !busy_pre) begin
      m_busy = 1; n_iss = 0; n_pop = 0;
      fifo_q.delete();
    end
  endtask

  task automatic pulse_start();
    start_req = 1;
    step();
    start_req = 0;
  endtask

  task automatic run_frame(int limit);
    int n = 0;
    while ((m_busy || m_fd) && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic clear_obs();
    seen_q.delete(); acc_addr_q.delete(); last_seen.delete(); eol_seen.delete();
    acc_seen = 0;
  endtask

  initial begin
    int fd0;
    rst = 1; start = 0;
    bus.ddr3_app_rdy = 0; bus.pix_ready = 0;
    bus.ddr3_app_rd_data_valid = 0; bus.ddr3_app_rd_data = '0;
    repeat (3) step();
    rst_req = 0;
    step();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_app_en", 64'(bus.ddr3_app_en), 64'(0));
    check("reset_app_addr", 64'(bus.ddr3_app_addr), 64'(0));
    check("reset_pix_valid", 64'(bus.pix_valid), 64'(0));

    // Test 1: full-rate frame, data = address
    clear_obs(); fd0 = fd_count;
    pulse_start();
    run_frame(200);
    repeat (2) step();
    check("t1_pixels", 64'(seen_q.size()), 64'(8));
    if (seen_q.size() == 8) begin
      check("t1_first_pix", seen_q[0], 64'(0));
      check("t1_last_pix", seen_q[7], 64'(56));
      check("t1_last_flag", 64'({last_seen[7], last_seen[6]}), 64'(2'b10));
      check("t1_last_addr", 64'(acc_addr_q[7]), 64'(56));
`ifdef FB_READER_EOL_EN
      check("t1_eol_mask", 64'({eol_seen[7], eol_seen[6], eol_seen[5], eol_seen[4],
                                eol_seen[3], eol_seen[2], eol_seen[1], eol_seen[0]}), 64'(8'h88));
`endif
    end
    check("t1_frame_done_count", 64'(fd_count - fd0), 64'(1));

    // Read beats while idle are dropped silently
    inject = 1; step(); inject = 0; step();
    check("idle_beat_no_ovf", 64'(overflow_err), 64'(0));
    check("idle_beat_no_pix", 64'(bus.pix_valid), 64'(0));

    // Test 3: command held while app_rdy is low
    rdy_pct = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_en", 64'(bus.ddr3_app_en), 64'(1));
      check("t3_hold_addr", 64'(bus.ddr3_app_addr), 64'(0));
    end
    rdy_pct = 100;
    run_frame(200);

    // Test 2 + 4: no pixel consumption caps reads at the FIFO depth, then overflow injection
    clear_obs(); pix_pct = 0; tag = 32'h0000_0002;
    pulse_start();
    repeat (20) step();
    check("t2_accepts", 64'(acc_seen), 64'(4));
    check("t2_app_en_low", 64'(bus.ddr3_app_en), 64'(0));
    check("t4_no_ovf_yet", 64'(overflow_err), 64'(0));
    inject = 1; step(); inject = 0; step();
    check("t4_ovf_set", 64'(overflow_err), 64'(1));
    pix_pct = 100;
    run_frame(200);
    step();
    check("t2_all_pixels", 64'(seen_q.size()), 64'(8));
    check("t4_ovf_sticky", 64'(overflow_err), 64'(1));
    rst_req = 1; step(); rst_req = 0; step();
    check("t4_ovf_cleared", 64'(overflow_err), 64'(0));

    // Test 5: reset after three pixels abandons the frame
    clear_obs(); tag = 32'h0000_0005;
    pulse_start();
    for (int i = 0; i < 200 && n_pop < 3; i++) step();
    fd0 = fd_count;
    rst_req = 1; step(); rst_req = 0; step();
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_app_addr", 64'(bus.ddr3_app_addr), 64'(0));
    check("t5_pix_valid", 64'(bus.pix_valid), 64'(0));
    repeat (8) step();
    check("t5_no_frame_done", 64'(fd_count - fd0), 64'(0));
    clear_obs();
    pulse_start();
    run_frame(200);
    check("t5_restart_count", 64'(acc_addr_q.size()), 64'(8));
    if (acc_addr_q.size() != 0) check("t5_restart_addr0", 64'(acc_addr_q[0]), 64'(0));

    // Randomized frames: backpressure, latency, start spam while busy, occasional mid-frame reset
    for (int f = 0; f < 30; f++) begin
      int rst_at;
      tag = $urandom;
      rdy_pct = int'($urandom_range(100, 30));
      pix_pct = int'($urandom_range(100, 20));
      lat_min = 1;
      lat_max = int'($urandom_range(6, 1));
      spam = 1;
      rst_at = (f % 5 == 4) ? int'($urandom_range(40, 2)) : -1;
      pulse_start();
      for (int n = 0; n < 400 && (m_busy || m_fd); n++) begin
        if (n == rst_at) rst_req = 1;
        step();
        rst_req = 0;
      end
      spam = 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
